// File: rtl/pe_wb_align_pkg.sv
// Shared Kyber constants for the PE0 writeback alignment block:
// modulus, widths, PE0 latencies and the control FSM encoding.
package pe_wb_align_pkg;

  // Kyber arithmetic and polynomial geometry.
  localparam int KYBER_Q  = 3329;
  localparam int KYBER_DW = 12;
  localparam int KYBER_AW = 8;

  // PE0 pipeline latencies (cycles from issue to result).
  localparam int KYBER_LAT_NTT     = 8;
  localparam int KYBER_LAT_INTT_U  = 14;
  localparam int KYBER_LAT_INTT_L  = 8;

  // Control FSM encoding; kept as plain constants so legacy tools can share it.
  localparam logic [1:0] ST_RUN    = 2'd0;
  localparam logic [1:0] ST_DRAIN  = 2'd1;
  localparam logic [1:0] ST_SWITCH = 2'd2;

  // Bits needed for a counter that must reach max_count inclusive.
  function automatic int cnt_width(input int max_count);
    return (max_count < 1) ? 1 : $clog2(max_count + 1);
  endfunction

endpackage

// File: rtl/pe_wb_align_delay.sv
// Fixed-depth shift register with synchronous reset and synchronous clear.
// A depth of zero degenerates into a wire so callers need no special case.
module pe_delay_line #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  generate
    if (DEPTH == 0) begin : g_bypass
      assign q = d;
    end else begin : g_shift
      logic [WIDTH-1:0] stage [DEPTH];

      // Shift one stage per cycle; reset and clear empty every stage.
      always_ff @(posedge clk) begin
        // NOTE: every stage is reset, not just the head, because stages carry
        // token valid bits that must never survive a reset or mode change.
        if (rst || clr) begin
          for (int i = 0; i < DEPTH; i++) begin
            stage[i] <= '0;
          end
        end else begin
          // NOTE: non-blocking assignments make each stage take its
          // neighbour's old value, which is what makes this a shift register.
          stage[0] <= d;
          for (int i = 1; i < DEPTH; i++) begin
            stage[i] <= stage[i-1];
          end
        end
      end

      assign q = stage[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/pe_wb_align.sv
// Writeback alignment for butterfly unit PE0. Tracks each issued butterfly
// as an address token, re-times it to the mode-dependent PE0 latency, and
// in INTT mode delays the early bf_lower result so both halves of a token
// are written together. Mode changes drain the pipe before pe_sel moves.
module pe_wb_align
  import pe_wb_align_pkg::*;
#(
  parameter int DW         = KYBER_DW,
  parameter int AW         = KYBER_AW,
  parameter int Q          = KYBER_Q,
  parameter int LAT_NTT    = KYBER_LAT_NTT,
  parameter int LAT_INTT_U = KYBER_LAT_INTT_U,
  parameter int LAT_INTT_L = KYBER_LAT_INTT_L
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          sel,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [AW-1:0] in_addr_u,
  input  logic [AW-1:0] in_addr_v,
  output logic          pe_sel,
  input  logic [DW-1:0] bf_upper,
  input  logic [DW-1:0] bf_lower,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr_u,
  output logic [AW-1:0] wr_addr_v,
  output logic [DW-1:0] wr_data_u,
  output logic [DW-1:0] wr_data_v,
  output logic          range_err
);

  localparam int CW   = cnt_width(LAT_INTT_U);
  localparam int TW   = 1 + 2 * AW;               // {valid, addr_u, addr_v}
  localparam int LDLY = LAT_INTT_U - LAT_INTT_L;  // bf_lower re-alignment
  localparam logic [DW:0] Q_EXT = (DW + 1)'(Q);

  logic [1:0]    state;
  logic [1:0]    state_next;
  logic          load_sel;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;
  logic          accept;
  logic [TW-1:0] tok_in;
  logic [TW-1:0] ntt_tok;
  logic [TW-1:0] intt_tok;
  logic [TW-1:0] out_tok;
  logic [DW-1:0] lower_dly;
  logic          lower_clr;

  // Issue handshake: only the RUN state accepts, never during reset.
  assign in_ready = (state == ST_RUN) && !rst;
  assign accept   = in_valid && in_ready;

  // Idle cycles inject an all-zero token so stale addresses never reach
  // the write port.
  assign tok_in = accept ? {1'b1, in_addr_u, in_addr_v} : '0;

  // One token line per latency; only the line for the active mode is fed.
  // The pipe is always empty when pe_sel changes, so at most one line
  // holds live tokens at any time.
  pe_delay_line #(
    .WIDTH (TW),
    .DEPTH (LAT_NTT)
  ) u_tok_ntt (
    .clk (clk),
    .rst (rst),
    .clr (1'b0),
    .d   (pe_sel ? '0 : tok_in),
    .q   (ntt_tok)
  );

  pe_delay_line #(
    .WIDTH (TW),
    .DEPTH (LAT_INTT_U)
  ) u_tok_intt (
    .clk (clk),
    .rst (rst),
    .clr (1'b0),
    .d   (pe_sel ? tok_in : '0),
    .q   (intt_tok)
  );

  // bf_lower leaves PE0 earlier than bf_upper in INTT mode; hold it back
  // so both halves of the same token meet at the write port. Flushed on a
  // mode switch so no pre-switch sample can be paired with a new token.
  assign lower_clr = (state == ST_SWITCH);

  pe_delay_line #(
    .WIDTH (DW),
    .DEPTH (LDLY)
  ) u_lower_dly (
    .clk (clk),
    .rst (rst),
    .clr (lower_clr),
    .d   (bf_lower),
    .q   (lower_dly)
  );

  // Writeback port: token addresses plus PE0 results in the token's cycle.
  assign out_tok   = ntt_tok[TW-1] ? ntt_tok : intt_tok;
  assign wr_en     = out_tok[TW-1];
  assign wr_addr_u = out_tok[2*AW-1:AW];
  assign wr_addr_v = out_tok[AW-1:0];
  assign wr_data_u = wr_en ? bf_upper : '0;
  assign wr_data_v = wr_en ? (pe_sel ? lower_dly : bf_lower) : '0;

  // In-flight token count: up on accept, down on writeback, still on both.
  always_comb begin
    // NOTE: default first, so every path assigns cnt_next and no latch forms.
    cnt_next = cnt;
    if (accept && !wr_en) begin
      cnt_next = cnt + CW'(1);
    end else if (!accept && wr_en) begin
      cnt_next = cnt - CW'(1);
    end
  end

  // Mode-change sequencing: RUN -> DRAIN (wait for empty pipe) -> SWITCH.
  // DRAIN looks at the next count so it leaves in the cycle of the last
  // writeback; pe_sel is loaded on that edge and SWITCH is the one extra
  // blocked cycle in which PE0 settles in its new mode.
  always_comb begin
    state_next = state;
    load_sel   = 1'b0;
    case (state)
      ST_RUN: begin
        if (sel != pe_sel) begin
          state_next = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (cnt_next == '0) begin
          state_next = ST_SWITCH;
          load_sel   = 1'b1;
        end
      end
      ST_SWITCH: begin
        state_next = ST_RUN;
      end
      default: begin
        state_next = ST_RUN;
      end
    endcase
  end

  // Control registers: FSM, counter, applied mode and sticky range flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_RUN;
      cnt       <= '0;
      pe_sel    <= 1'b0;
      range_err <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      if (load_sel) begin
        pe_sel <= sel;
      end
      if (wr_en && (({1'b0, wr_data_u} >= Q_EXT) || ({1'b0, wr_data_v} >= Q_EXT))) begin
        range_err <= 1'b1;
      end
    end
  end

endmodule

// File: doc/pe_wb_align.md
PE_WB_ALIGN -- requirements
Module: pe_wb_align

Interface
REQ-001 Parameter DW, default 12, coefficient width.
REQ-002 Parameter AW, default 8, coefficient address width (256-coefficient polynomial).
REQ-003 Parameter Q, default 3329, modulus used for the output range check.
REQ-004 Parameter LAT_NTT, default 8, PE0 latency for both outputs when sel=0.
REQ-005 Parameter LAT_INTT_U, default 14, PE0 bf_upper latency when sel=1.
REQ-006 Parameter LAT_INTT_L, default 8, PE0 bf_lower latency when sel=1; SHALL be <= LAT_INTT_U.
REQ-007 clk  input  1  single clock, rising edge.
REQ-008 rst  input  1  synchronous active-high reset.
REQ-009 sel  input  1  requested mode: 0=NTT, 1=INTT; drives PE0 sel via pe_sel.
REQ-010 in_valid  input  1  butterfly issued to PE0 this cycle.
REQ-011 in_ready  output  1  block accepts an issue this cycle.
REQ-012 in_addr_u, in_addr_v  input  AW each  writeback addresses of the issued pair.
REQ-013 pe_sel  output  1  registered mode applied to PE0.
REQ-014 bf_upper, bf_lower  input  DW each  PE0 outputs.
REQ-015 wr_en  output  1  writeback strobe.
REQ-016 wr_addr_u, wr_addr_v  output  AW each  writeback addresses.
REQ-017 wr_data_u, wr_data_v  output  DW each  aligned butterfly results.
REQ-018 range_err  output  1  sticky flag: any written value >= Q.

Function
REQ-019 An issue SHALL be accepted only when in_valid && in_ready; an accepted issue is a token carrying {in_addr_u, in_addr_v}.
REQ-020 Each token SHALL appear at the output exactly L cycles after acceptance, where L=LAT_NTT when pe_sel=0 and L=LAT_INTT_U when pe_sel=1; wr_en SHALL be 1 in that cycle only.
REQ-021 In NTT mode wr_data_u=bf_upper and wr_data_v=bf_lower sampled in the wr_en cycle.
REQ-022 In INTT mode wr_data_v SHALL be bf_lower delayed by LAT_INTT_U-LAT_INTT_L cycles, so both outputs belong to the same token.
REQ-023 Back-to-back issues (one per cycle) SHALL be supported with no bubbles; outputs emerge in issue order.
REQ-024 Control FSM states: RUN, DRAIN, SWITCH.
REQ-025 RUN: in_ready=1 while sel==pe_sel; on sel!=pe_sel go to DRAIN, in_ready=0.
REQ-026 DRAIN: in_ready=0 until the token count in flight reaches 0, then go to SWITCH.
REQ-027 SWITCH: load pe_sel<=sel, clear lower-delay line, hold in_ready=0 for exactly one further cycle, then RUN.
REQ-028 If the pipe is empty when sel changes, DRAIN SHALL last exactly one cycle.
REQ-029 If sel reverts to pe_sel during DRAIN, the FSM SHALL still complete DRAIN and SWITCH (no abort).
REQ-030 In-flight counter width SHALL hold LAT_INTT_U; increment on accept, decrement on wr_en, unchanged on both.
REQ-031 range_err SHALL set when wr_en=1 and wr_data_u>=Q or wr_data_v>=Q; clears only on rst.

Reset
REQ-032 On rst: wr_en=0, wr_addr_*=0, wr_data_*=0, range_err=0, pe_sel=0, FSM=RUN, counter=0, all token valid bits cleared; in_ready=0 during the rst cycle.
REQ-033 Reset mid-operation SHALL discard all in-flight tokens; no wr_en for them afterwards.

Structure
REQ-034 Q, DW, AW, latency constants and FSM state encoding SHALL live in the shared kyber package.
REQ-035 One sub-module pe_delay_line (parameterised width/depth shift register with sync clear) SHALL be used for the token line and lower-data delay.

Verification
REQ-036 NTT, 3 back-to-back issues addr (0,128),(1,129),(2,130) at cycle 10 -> wr_en at cycles 18,19,20 with those addresses in order.
REQ-037 INTT, one issue at cycle 10 with PE0 model u=0x005,v=0x003 -> wr_en at cycle 24, data_u/data_v match model values of same token.
REQ-038 sel 0->1 with 4 tokens in flight -> in_ready low until last NTT wr_en, then pe_sel=1 one cycle later, in_ready high after SWITCH.
REQ-039 sel toggled with empty pipe -> in_ready low exactly 2 cycles.
REQ-040 rst asserted 3 cycles after 5 issues -> no wr_en afterwards, all outputs 0.
REQ-041 PE0 model returns 0xD01 (3329) -> range_err=1 and stays 1 until rst.
